// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequencer/arbiter for an 8 x 24-bit TLB RAM (sync write, async read).
// Ports: clk/rst; flush/write/lookup requests; RAM port (addr/data/we/q); status and result outputs.
//
// Requests:  flush_req, wr_req (+ wr_rand, wr_index, wr_vpn, wr_pfn), lk_req (+ lk_vpn)
// RAM side:  ram_addr, ram_data, ram_we out; ram_q in (combinational from ram_addr)
// Results:   busy, done (1-cycle pulse), hit, lk_pfn, lk_index, rr_ptr
module tlb_ctrl #(
    parameter int VPN_W = 12,
    parameter int PFN_W = 11,
    parameter int IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_req,
    input  logic                   wr_req,
    input  logic                   wr_rand,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [VPN_W-1:0]       wr_vpn,
    input  logic [PFN_W-1:0]       wr_pfn,
    input  logic                   lk_req,
    input  logic [VPN_W-1:0]       lk_vpn,
    output logic [IDX_W-1:0]       ram_addr,
    output logic [VPN_W+PFN_W:0]   ram_data,
    output logic                   ram_we,
    input  logic [VPN_W+PFN_W:0]   ram_q,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic [PFN_W-1:0]       lk_pfn,
    output logic [IDX_W-1:0]       lk_index,
    output logic [IDX_W-1:0]       rr_ptr
);

    localparam int ENT_W = 1 + VPN_W + PFN_W;
    localparam logic [IDX_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PFN_W-1:0] pfn_q, pfn_d;
    logic             rand_q, rand_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic [PFN_W-1:0] lk_pfn_q, lk_pfn_d;
    logic [IDX_W-1:0] lk_index_q, lk_index_d;

    logic             ent_match;
    logic             scan_last;
    logic             we_raw;

    // vpn_q holds the lookup tag in SCAN and the write tag in WRITE.
    assign ent_match = ram_q[ENT_W-1]
                     && (ram_q[ENT_W-2 -: VPN_W] == vpn_q);
    assign scan_last = (cnt_q == LAST);

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                priority case (1'b1)
                    flush_req: state_d = S_FLUSH;
                    wr_req:    state_d = S_WRITE;
                    lk_req:    state_d = S_SCAN;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_SCAN: begin
                if (ent_match || scan_last) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (scan_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------
    // FSM: RAM port and busy
    // ------------------------------------------------------------
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        we_raw   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ram_addr = '0;
            end
            S_SCAN: begin
                ram_addr = cnt_q;
            end
            S_WRITE: begin
                ram_addr = tgt_q;
                ram_data = {1'b1, vpn_q, pfn_q};
                we_raw   = 1'b1;
            end
            S_FLUSH: begin
                ram_addr = cnt_q;
                we_raw   = 1'b1;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    // A reset cycle must never write, even in the middle of WRITE/FLUSH.
    assign ram_we = we_raw & ~rst;
    assign busy   = (state_q != S_IDLE);

    // ------------------------------------------------------------
    // Datapath: latches, counters, results
    // ------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        tgt_d      = tgt_q;
        vpn_d      = vpn_q;
        pfn_d      = pfn_q;
        rand_d     = rand_q;
        done_d     = 1'b0;
        hit_d      = hit_q;
        lk_pfn_d   = lk_pfn_q;
        lk_index_d = lk_index_q;
        unique case (state_q)
            S_IDLE: begin
                priority case (1'b1)
                    flush_req: begin
                        cnt_d = '0;
                    end
                    wr_req: begin
                        tgt_d  = wr_rand ? rr_ptr_q : wr_index;
                        vpn_d  = wr_vpn;
                        pfn_d  = wr_pfn;
                        rand_d = wr_rand;
                    end
                    lk_req: begin
                        vpn_d = lk_vpn;
                        cnt_d = '0;
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
            S_SCAN: begin
                if (ent_match) begin
                    done_d     = 1'b1;
                    hit_d      = 1'b1;
                    lk_pfn_d   = ram_q[PFN_W-1:0];
                    lk_index_d = cnt_q;
                end else if (scan_last) begin
                    // Miss: pfn/index keep their previous values.
                    done_d = 1'b1;
                    hit_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_WRITE: begin
                done_d     = 1'b1;
                hit_d      = 1'b0;
                lk_index_d = tgt_q;
                if (rand_q) begin
                    // Natural wrap 7 -> 0.
                    rr_ptr_d = rr_ptr_q + IDX_W'(1);
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (scan_last) begin
                    done_d   = 1'b1;
                    hit_d    = 1'b0;
                    rr_ptr_d = '0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            tgt_q      <= '0;
            vpn_q      <= '0;
            pfn_q      <= '0;
            rand_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            lk_pfn_q   <= '0;
            lk_index_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            tgt_q      <= tgt_d;
            vpn_q      <= vpn_d;
            pfn_q      <= pfn_d;
            rand_q     <= rand_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            lk_pfn_q   <= lk_pfn_d;
            lk_index_q <= lk_index_d;
        end
    end

    assign done     = done_q;
    assign hit      = hit_q;
    assign lk_pfn   = lk_pfn_q;
    assign lk_index = lk_index_q;
    assign rr_ptr   = rr_ptr_q;

endmodule
